foobar: RTL and testbench
=========================

Name: foobar

Overview:
- Enable-gated event counter with two divisibility detectors ("foo" on multiples of FOO_DIV, "bar" on multiples of BAR_DIV).
- Produces registered pulses and running tallies of each pulse type.
- Standalone leaf block for scoreboarding and demo; no handshake with neighbours.

Parameters:
- WIDTH, 8, bit width of count, count_foo and count_bar.
- FOO_DIV, 3, divisor for foo; legal range 2..2^WIDTH-1.
- BAR_DIV, 5, divisor for bar; legal range 2..2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- en  input  1  advance enable, sampled on rising clk.
- foo  output  1  registered; 1 for the cycle after an enabled edge that leaves count ≡ 0 mod FOO_DIV.
- bar  output  1  registered; same rule with BAR_DIV.
- count  output  WIDTH  number of enabled edges, modulo 2^WIDTH.
- count_foo  output  WIDTH  number of foo pulses, modulo 2^WIDTH.
- count_bar  output  WIDTH  number of bar pulses, modulo 2^WIDTH.

Behaviour:
- Reset (rst=0, asynchronous): count, count_foo, count_bar = 0; foo = bar = 0; internal phase counters = 0. Outputs hold reset values while rst=0, regardless of clk and en.
- Enabled edge (rising clk with en=1):
  - count <= count+1; wraps 2^WIDTH-1 -> 0.
  - foo_phase tracks count mod FOO_DIV incrementally; no divider or % operator. It increments and wraps at FOO_DIV-1 -> 0, and is forced to 0 whenever count wraps to 0. The phase is defined on count's value, not on the total number of edges.
  - bar_phase follows the same rule with BAR_DIV.
  - foo <= (next foo_phase == 0); bar <= (next bar_phase == 0).
  - count_foo increments by 1 when next foo=1; count_bar increments by 1 when next bar=1. Both wrap modulo 2^WIDTH.
- Disabled edge (en=0): count, phases and tallies hold; foo <= 0, bar <= 0.
- Pulse shape: foo and bar are one-cycle pulses; consecutive pulses occur only if consecutive enabled edges both hit a multiple.
- Simultaneous hit: count a common multiple (e.g. 15, or 0 after wrap): foo=1 and bar=1 in the same cycle; both tallies increment.
- Latency: all outputs change exactly one edge after the en sample; no combinational path from en to any output.
- Reset mid-operation: immediate clear of every output and phase; the count sequence restarts at 1 on the first enabled edge after release.

Optional Feature:
- FOOBAR_SAT_EN defined: count_foo and count_bar saturate at 2^WIDTH-1 and hold there. count still wraps.
- FOOBAR_SAT_EN undefined: both tallies wrap to 0 like count.

Decomposition:
- Package foobar_pkg holds:
  - the default constants FOOBAR_WIDTH=8, FOOBAR_FOO_DIV=3, FOOBAR_BAR_DIV=5;
  - typedef foobar_cnt_t, a WIDTH-bit logic vector.
- One sub-module, foobar_detector, instantiated twice (FOO_DIV and BAR_DIV). Each instance contains:
  - the phase counter with its wrap/clear input driven by count wrap;
  - the pulse register;
  - the tally register, including the saturation option.
- Top level holds count and the wrap detect.

Test Plan:
- Reset then 15 enabled edges -> count=15, foo pulses after edges 3,6,9,12,15, bar pulses after edges 5,10,15; count_foo=5, count_bar=3; foo=bar=1 after edge 15.
- en=1 for 7 edges, en=0 for 4 edges, en=1 for 2 edges -> count holds 7 during the gap with foo=bar=0; after the 9th enabled edge count=9, foo=1, count_foo=3, count_bar=1.
- 256 enabled edges -> after edge 255, count=255, count_foo=85, count_bar=51; after edge 256, count=0, foo=bar=1, count_foo=86, count_bar=52. The phase restarts: next foo pulse at count=3.
- Assert rst=0 asynchronously mid-cycle at count=10 -> all outputs 0 before the next clk edge. After release, first enabled edge gives count=1, foo=bar=0.
- FOOBAR_SAT_EN defined, WIDTH=4, FOO_DIV=2, 40 enabled edges -> count_foo stops at 15 and holds; count wraps normally. Undefined: count_foo wraps (40 edges -> 4).
- en toggled every cycle for 30 cycles -> count=15; foo/bar pulses only on cycles following enabled edges; tallies 5 and 3.

Source files
------------

// File: rtl/foobar_pkg.sv
// Shared constants and types for the foobar event counter.
// Holds default WIDTH/divisor values and the count vector type.
package foobar_pkg;

    localparam int FOOBAR_WIDTH   = 8;
    localparam int FOOBAR_FOO_DIV = 3;
    localparam int FOOBAR_BAR_DIV = 5;

    typedef logic [FOOBAR_WIDTH-1:0] foobar_cnt_t;

endpackage

// File: rtl/foobar_detector.sv
// Divisibility detector: phase counter, registered pulse, pulse tally.
// Ports: clk, rst (async, active-low), en (advance), wrap (count
// about to roll over to 0), pulse (registered hit), tally (hit count).
// FOOBAR_SAT_EN: tally saturates at all-ones instead of wrapping.
module foobar_detector
    import foobar_pkg::*;
#(
    parameter int WIDTH = FOOBAR_WIDTH,
    parameter int DIV   = FOOBAR_FOO_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    output logic             pulse,
    output logic [WIDTH-1:0] tally
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] phase;
    logic [WIDTH-1:0] phase_nxt;
    logic             hit;

    // Phase mirrors count mod DIV; a count rollover to 0 re-aligns it.
    always_comb begin
        phase_nxt = phase;
        if (en) begin
            if (wrap || phase == LAST) begin
                phase_nxt = '0;
            end else begin
                phase_nxt = phase + ONE;
            end
        end
    end

    assign hit = en && (phase_nxt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            pulse <= 1'b0;
            tally <= '0;
        end else begin
            phase <= phase_nxt;
            pulse <= hit;
`ifdef FOOBAR_SAT_EN
            if (hit && tally != '1) begin
                tally <= tally + ONE;
            end
`else
            if (hit) begin
                tally <= tally + ONE;
            end
`endif
        end
    end

endmodule

// File: rtl/foobar.sv
// Enable-gated event counter with foo/bar divisibility pulses and tallies.
// Ports: clk, rst (async, active-low), en; outputs foo, bar, count,
// count_foo, count_bar. FOOBAR_SAT_EN makes the tallies saturate.
module foobar
    import foobar_pkg::*;
#(
    parameter int WIDTH   = FOOBAR_WIDTH,
    parameter int FOO_DIV = FOOBAR_FOO_DIV,
    parameter int BAR_DIV = FOOBAR_BAR_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             foo,
    output logic             bar,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_foo,
    output logic [WIDTH-1:0] count_bar
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic wrap;

    // Next enabled edge rolls count over to 0.
    assign wrap = (count == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

    foobar_detector #(
        .WIDTH (WIDTH),
        .DIV   (FOO_DIV)
    ) u_foo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .wrap  (wrap),
        .pulse (foo),
        .tally (count_foo)
    );

    foobar_detector #(
        .WIDTH (WIDTH),
        .DIV   (BAR_DIV)
    ) u_bar (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .wrap  (wrap),
        .pulse (bar),
        .tally (count_bar)
    );

endmodule

// File: tb/tb_foobar.sv
// Scoreboard bench for foobar: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_foobar;

    logic       clk;
    logic       rst;
    logic       en;
    logic       foo;
    logic       bar;
    logic [7:0] count;
    logic [7:0] count_foo;
    logic [7:0] count_bar;

    logic       en2;
    logic       foo2;
    logic       bar2;
    logic [3:0] count2;
    logic [3:0] count_foo2;
    logic [3:0] count_bar2;

    foobar #(
        .WIDTH   (8),
        .FOO_DIV (3),
        .BAR_DIV (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .foo       (foo),
        .bar       (bar),
        .count     (count),
        .count_foo (count_foo),
        .count_bar (count_bar)
    );

    foobar #(
        .WIDTH   (4),
        .FOO_DIV (2),
        .BAR_DIV (5)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en2),
        .foo       (foo2),
        .bar       (bar2),
        .count     (count2),
        .count_foo (count_foo2),
        .count_bar (count_bar2)
    );

    typedef struct {
        int    c;
        int    f;
        int    b;
        int    cf;
        int    cb;
        string nm;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    int   m_count;
    int   m_cf;
    int   m_cb;
    int   m_f;
    int   m_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int tally_inc(input int t);
`ifdef FOOBAR_SAT_EN
        return (t == 255) ? 255 : t + 1;
`else
        return (t + 1) % 256;
`endif
    endfunction

    // Independent reference: uses the % operator on the count value.
    task automatic model(input logic e);
        if (e) begin
            m_count = (m_count + 1) % 256;
            m_f     = (m_count % 3 == 0) ? 1 : 0;
            m_b     = (m_count % 5 == 0) ? 1 : 0;
            if (m_f == 1) m_cf = tally_inc(m_cf);
            if (m_b == 1) m_cb = tally_inc(m_cb);
        end else begin
            m_f = 0;
            m_b = 0;
        end
    endtask

    task automatic step(input logic e);
        exp_t x;
        en = e;
        @(posedge clk);
        #1;
        model(e);
        x.c  = m_count;
        x.f  = m_f;
        x.b  = m_b;
        x.cf = m_cf;
        x.cb = m_cb;
        x.nm = "model";
        q.push_back(x);
    endtask

    // Hand-computed expectation replaces the model's for this edge.
    task automatic step_hc(input logic e, input int c, input int f,
                           input int b, input int cf, input int cb,
                           input string nm);
        exp_t x;
        en = e;
        @(posedge clk);
        #1;
        model(e);
        x.c  = c;
        x.f  = f;
        x.b  = b;
        x.cf = cf;
        x.cb = cb;
        x.nm = nm;
        q.push_back(x);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_count"}, int'(count), 0);
        chk({nm, "_foo"}, int'(foo), 0);
        chk({nm, "_bar"}, int'(bar), 0);
        chk({nm, "_cfoo"}, int'(count_foo), 0);
        chk({nm, "_cbar"}, int'(count_bar), 0);
    endtask

    task automatic do_reset();
        en  = 1'b0;
        en2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        m_count = 0;
        m_cf    = 0;
        m_cb    = 0;
        m_f     = 0;
        m_b     = 0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, "_count"}, int'(count), e.c);
            chk({e.nm, "_foo"}, int'(foo), e.f);
            chk({e.nm, "_bar"}, int'(bar), e.b);
            chk({e.nm, "_cfoo"}, int'(count_foo), e.cf);
            chk({e.nm, "_cbar"}, int'(count_bar), e.cb);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        en2    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_zero("por");

        // 15 enabled edges
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            if (i == 3)
                step_hc(1'b1, 3, 1, 0, 1, 0, "e3");
            else if (i == 5)
                step_hc(1'b1, 5, 0, 1, 1, 1, "e5");
            else if (i == 15)
                step_hc(1'b1, 15, 1, 1, 5, 3, "e15");
            else
                step(1'b1);
        end

        // 7 on, 4 off, 2 on
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1);
        for (int i = 0; i < 4; i++)
            step_hc(1'b0, 7, 0, 0, 2, 1, "gap");
        step(1'b1);
        step_hc(1'b1, 9, 1, 0, 3, 1, "e9");

        // full wrap
        do_reset();
        for (int i = 1; i <= 254; i++) step(1'b1);
        step_hc(1'b1, 255, 1, 1, 85, 51, "e255");
        step_hc(1'b1, 0, 1, 1, 86, 52, "e256");
        step_hc(1'b1, 1, 0, 0, 86, 52, "e257");
        step(1'b1);
        step_hc(1'b1, 3, 1, 0, 87, 52, "e259");

        // async reset mid-cycle
        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_zero("async");
        en = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("hold");
        @(negedge clk);
        rst = 1'b1;
        m_count = 0;
        m_cf    = 0;
        m_cb    = 0;
        step_hc(1'b1, 1, 0, 0, 0, 0, "rel1");

        // narrow instance: tally wrap / saturation
        do_reset();
        en2 = 1'b1;
        for (int i = 0; i < 40; i++) @(posedge clk);
        #1;
        en2 = 1'b0;
        chk("w4_count", int'(count2), 8);
`ifdef FOOBAR_SAT_EN
        chk("w4_cfoo", int'(count_foo2), 15);
`else
        chk("w4_cfoo", int'(count_foo2), 4);
`endif

        // en toggling
        do_reset();
        for (int i = 0; i < 28; i++) step((i % 2) == 0);
        step_hc(1'b1, 15, 1, 1, 5, 3, "tog15");
        step_hc(1'b0, 15, 0, 0, 5, 3, "togend");

        en = 1'b0;
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        chk("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
